blob_bbox_extractor: RTL and testbench
======================================

Name: blob_bbox_extractor

Overview:
Consumes a raster pixel stream and a per-pixel colour-match mask. Accumulates pixel count, coordinate sums and min/max extents over one frame. At frame end it runs a fixed-latency iterative divide to produce the blob centroid and bounding box. Outputs feed directly into the minmax/centre-of-mass block sprite renderers and the game logic: pixel stream in, sprite coordinates out.

Parameters:
MIN_PIXELS, 16, minimum matched-pixel count for found_out=1
COUNT_W, 22, matched-pixel counter width
SUMX_W, 33, x-coordinate sum width
SUMY_W, 32, y-coordinate sum width

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
hcount_in  in  11  pixel x coordinate
vcount_in  in  10  pixel y coordinate
valid_in  in  1  pixel is in the active region
mask_in  in  1  pixel matches target colour
frame_end_in  in  1  one-cycle pulse on the last active pixel of a frame
x_out  out  11  centroid x, floor(sum_x/count)
y_out  out  10  centroid y, floor(sum_y/count)
xmin_out  out  12  bounding-box left (zero-extended)
ymin_out  out  11  bounding-box top
xmax_out  out  12  bounding-box right, inclusive
ymax_out  out  11  bounding-box bottom, inclusive
count_out  out  COUNT_W  matched pixels in the frame
found_out  out  1  count_out >= MIN_PIXELS
valid_out  out  1  one-cycle pulse when results update
dropped_out  out  1  one-cycle pulse when a frame result is discarded

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-high on rst_in.
- Reset values: all outputs 0. Accumulators are cleared: count=0, sums=0, xmin=2047, ymin=1023, xmax=0, ymax=0. State is ACCUM.
- Qualified pixel: valid_in && mask_in. On each qualified pixel:
  - count += 1; sum_x += hcount_in; sum_y += vcount_in.
  - xmin/xmax and ymin/ymax update with the usual min/max compare.
- frame_end_in cycle:
  - A qualified pixel in the same cycle is included in the ending frame.
  - Next cycle, accumulators hold reset values and accumulation of the new frame begins.
  - Accumulation runs continuously in every state. It never stalls.
- State ACCUM: on frame_end_in, snapshot the final totals, including the same-cycle pixel, into shadow registers. Go to DIVIDE.
- State DIVIDE:
  - Two restoring dividers run in parallel, 1 quotient bit per cycle: sum_x/count and sum_y/count.
  - Always exactly 33 cycles, regardless of operand values. The y divider is padded to match.
  - Then go to DONE.
- State DONE, one cycle:
  - Register all outputs from the shadow registers and quotients.
  - Pulse valid_out. Return to ACCUM.
- Latency: if frame_end_in is high in cycle T, valid_out is high in cycle T+34 only. Results change only in that cycle and hold until the next valid_out.
- Empty frame (count=0):
  - The divide still takes 33 cycles.
  - x_out, y_out, xmin_out, ymin_out, xmax_out, ymax_out, count_out and found_out are all 0.
  - valid_out still pulses.
- Below threshold (0 < count < MIN_PIXELS): found_out=0, but centroid, bbox and count are reported normally.
- frame_end_in while in DIVIDE or DONE:
  - The accumulators still clear and that frame's totals are discarded.
  - dropped_out pulses the next cycle.
  - The in-flight result completes unaffected.
- Widths: sums never overflow for frames of 2048x1024 or smaller. Quotient bits above the output width are provably 0 and are truncated.
- Reset mid-DIVIDE: abort the divide, no valid_out, outputs go to 0 next cycle.

Test Plan:
- Single qualified pixel at (100,50), MIN_PIXELS=1, frame_end_in at T -> valid_out only at T+34; x=100, y=50, xmin=xmax=100, ymin=ymax=50, count=1, found=1.
- 10x10 block at x 200..209, y 300..309 -> x=204, y=304, bbox (200,300)-(209,309), count=100, found=1.
- Frame with no qualified pixels -> valid_out pulses; all outputs 0, found=0.
- Three pixels (10,10), (20,10), (30,40), MIN_PIXELS=16 -> count=3, x=20, y=20, bbox (10,10)-(30,40), found=0.
- Second frame_end_in 10 cycles after the first -> dropped_out pulses once; the first frame's result appears at T+34 correct; next full frame reports normally.
- rst_in asserted for one cycle 15 cycles into DIVIDE -> no valid_out; all outputs 0; next frame's result correct.

Source files
------------

// File: rtl/blob_bbox_extractor.sv
// Accumulates matched-pixel count, coordinate sums and extents per frame; divides out the centroid at frame end.
// Results appear 34 cycles after frame_end_in. The input is never stalled: a frame ending while a divide is busy is dropped.
module blob_bbox_extractor #(
    parameter int MIN_PIXELS = 16,
    parameter int COUNT_W    = 22,
    parameter int SUMX_W     = 33,
    parameter int SUMY_W     = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [10:0]        hcount_in,
    input  logic [9:0]         vcount_in,
    input  logic               valid_in,
    input  logic               mask_in,
    input  logic               frame_end_in,
    output logic [10:0]        x_out,
    output logic [9:0]         y_out,
    output logic [11:0]        xmin_out,
    output logic [10:0]        ymin_out,
    output logic [11:0]        xmax_out,
    output logic [10:0]        ymax_out,
    output logic [COUNT_W-1:0] count_out,
    output logic               found_out,
    output logic               valid_out,
    output logic               dropped_out
);

    // Both dividers share the x dividend width, so the y divide is padded to the same length.
    localparam int QW     = SUMX_W;
    localparam int ITER_W = $clog2(QW + 1);
    localparam logic [ITER_W-1:0]  LAST_ITER = ITER_W'(QW - 1);
    localparam logic [COUNT_W-1:0] MIN_CNT   = COUNT_W'(MIN_PIXELS);

    typedef enum logic [1:0] {
        ACCUM,
        DIVIDE,
        DONE
    } state_t;

    state_t state;

    logic [COUNT_W-1:0] acc_count;
    logic [SUMX_W-1:0]  acc_sum_x;
    logic [SUMY_W-1:0]  acc_sum_y;
    logic [10:0]        acc_xmin;
    logic [10:0]        acc_xmax;
    logic [9:0]         acc_ymin;
    logic [9:0]         acc_ymax;

    logic               pix;
    logic [COUNT_W-1:0] count_nxt;
    logic [SUMX_W-1:0]  sum_x_nxt;
    logic [SUMY_W-1:0]  sum_y_nxt;
    logic [10:0]        xmin_nxt;
    logic [10:0]        xmax_nxt;
    logic [9:0]         ymin_nxt;
    logic [9:0]         ymax_nxt;

    logic [COUNT_W-1:0] sh_count;
    logic [10:0]        sh_xmin;
    logic [10:0]        sh_xmax;
    logic [9:0]         sh_ymin;
    logic [9:0]         sh_ymax;

    logic [COUNT_W-1:0] rem_x;
    logic [COUNT_W-1:0] rem_y;
    logic [QW-1:0]      quo_x;
    logic [QW-1:0]      quo_y;
    logic [ITER_W-1:0]  iter;

    logic [COUNT_W+QW-1:0] step_x;
    logic [COUNT_W+QW-1:0] step_y;

    // One restoring-division step: returns {remainder, quotient/dividend shift register}.
    function automatic logic [COUNT_W+QW-1:0] div_step(
        input logic [COUNT_W-1:0] rem,
        input logic [QW-1:0]      quo,
        input logic [COUNT_W-1:0] dvs
    );
        logic [COUNT_W:0] trial;
        logic [COUNT_W:0] diff;
        trial = {rem, quo[QW-1]};
        diff  = trial - {1'b0, dvs};
        if (trial >= {1'b0, dvs}) begin
            div_step = {diff[COUNT_W-1:0], quo[QW-2:0], 1'b1};
        end else begin
            div_step = {trial[COUNT_W-1:0], quo[QW-2:0], 1'b0};
        end
    endfunction

    // Totals including this cycle's pixel, so a pixel coincident with frame_end_in lands in the snapshot.
    always_comb begin
        pix       = valid_in && mask_in;
        count_nxt = acc_count;
        sum_x_nxt = acc_sum_x;
        sum_y_nxt = acc_sum_y;
        xmin_nxt  = acc_xmin;
        xmax_nxt  = acc_xmax;
        ymin_nxt  = acc_ymin;
        ymax_nxt  = acc_ymax;
        if (pix) begin
            count_nxt = acc_count + COUNT_W'(1);
            sum_x_nxt = acc_sum_x + SUMX_W'(hcount_in);
            sum_y_nxt = acc_sum_y + SUMY_W'(vcount_in);
            if (hcount_in < acc_xmin) xmin_nxt = hcount_in;
            if (hcount_in > acc_xmax) xmax_nxt = hcount_in;
            if (vcount_in < acc_ymin) ymin_nxt = vcount_in;
            if (vcount_in > acc_ymax) ymax_nxt = vcount_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || frame_end_in) begin
            acc_count <= '0;
            acc_sum_x <= '0;
            acc_sum_y <= '0;
            acc_xmin  <= 11'd2047;
            acc_xmax  <= '0;
            acc_ymin  <= 10'd1023;
            acc_ymax  <= '0;
        end else begin
            acc_count <= count_nxt;
            acc_sum_x <= sum_x_nxt;
            acc_sum_y <= sum_y_nxt;
            acc_xmin  <= xmin_nxt;
            acc_xmax  <= xmax_nxt;
            acc_ymin  <= ymin_nxt;
            acc_ymax  <= ymax_nxt;
        end
    end

    assign step_x = div_step(rem_x, quo_x, sh_count);
    assign step_y = div_step(rem_y, quo_y, sh_count);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= ACCUM;
            sh_count    <= '0;
            sh_xmin     <= '0;
            sh_xmax     <= '0;
            sh_ymin     <= '0;
            sh_ymax     <= '0;
            rem_x       <= '0;
            rem_y       <= '0;
            quo_x       <= '0;
            quo_y       <= '0;
            iter        <= '0;
            x_out       <= '0;
            y_out       <= '0;
            xmin_out    <= '0;
            ymin_out    <= '0;
            xmax_out    <= '0;
            ymax_out    <= '0;
            count_out   <= '0;
            found_out   <= 1'b0;
            valid_out   <= 1'b0;
            dropped_out <= 1'b0;
        end else begin
            valid_out   <= 1'b0;
            dropped_out <= frame_end_in && (state != ACCUM);
            case (state)
                ACCUM: begin
                    if (frame_end_in) begin
                        sh_count <= count_nxt;
                        sh_xmin  <= xmin_nxt;
                        sh_xmax  <= xmax_nxt;
                        sh_ymin  <= ymin_nxt;
                        sh_ymax  <= ymax_nxt;
                        quo_x    <= QW'(sum_x_nxt);
                        quo_y    <= QW'(sum_y_nxt);
                        rem_x    <= '0;
                        rem_y    <= '0;
                        iter     <= '0;
                        state    <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem_x <= step_x[COUNT_W+QW-1:QW];
                    quo_x <= step_x[QW-1:0];
                    rem_y <= step_y[COUNT_W+QW-1:QW];
                    quo_y <= step_y[QW-1:0];
                    iter  <= iter + ITER_W'(1);
                    // The final step's quotient goes straight to the outputs so valid_out lines up with DONE.
                    if (iter == LAST_ITER) begin
                        state     <= DONE;
                        valid_out <= 1'b1;
                        if (sh_count == '0) begin
                            x_out     <= '0;
                            y_out     <= '0;
                            xmin_out  <= '0;
                            ymin_out  <= '0;
                            xmax_out  <= '0;
                            ymax_out  <= '0;
                            count_out <= '0;
                            found_out <= 1'b0;
                        end else begin
                            x_out     <= step_x[10:0];
                            y_out     <= step_y[9:0];
                            xmin_out  <= {1'b0, sh_xmin};
                            ymin_out  <= {1'b0, sh_ymin};
                            xmax_out  <= {1'b0, sh_xmax};
                            ymax_out  <= {1'b0, sh_ymax};
                            count_out <= sh_count;
                            found_out <= (sh_count >= MIN_CNT);
                        end
                    end
                end
                DONE: begin
                    state <= ACCUM;
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blob_bbox_extractor.sv
// Directed bench: two instances (MIN_PIXELS=16 and MIN_PIXELS=1) share one pixel stream.
module tb_blob_bbox_extractor;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        valid_in;
    logic        mask_in;
    logic        frame_end_in;

    logic [10:0] x_out, x1;
    logic [9:0]  y_out, y1;
    logic [11:0] xmin_out, xmin1, xmax_out, xmax1;
    logic [10:0] ymin_out, ymin1, ymax_out, ymax1;
    logic [21:0] count_out, count1;
    logic        found_out, found1;
    logic        valid_out, valid1;
    logic        dropped_out, dropped1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fe_c;

    always #5 clk_in = ~clk_in;

    blob_bbox_extractor dut (
        .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .valid_in(valid_in), .mask_in(mask_in), .frame_end_in(frame_end_in),
        .x_out(x_out), .y_out(y_out), .xmin_out(xmin_out), .ymin_out(ymin_out),
        .xmax_out(xmax_out), .ymax_out(ymax_out), .count_out(count_out),
        .found_out(found_out), .valid_out(valid_out), .dropped_out(dropped_out)
    );

    blob_bbox_extractor #(.MIN_PIXELS(1)) dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .valid_in(valid_in), .mask_in(mask_in), .frame_end_in(frame_end_in),
        .x_out(x1), .y_out(y1), .xmin_out(xmin1), .ymin_out(ymin1),
        .xmax_out(xmax1), .ymax_out(ymax1), .count_out(count1),
        .found_out(found1), .valid_out(valid1), .dropped_out(dropped1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Inputs are applied for one full cycle; outputs are then sampled 1 time unit after the edge.
    task automatic drive(input int h, input int v, input logic vld, input logic msk, input logic fe);
        hcount_in    = 11'(h);
        vcount_in    = 10'(v);
        valid_in     = vld;
        mask_in      = msk;
        frame_end_in = fe;
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_result(input int fe_cycle, input string tag);
        logic early;
        early = 1'b0;
        while (cyc < fe_cycle + 34) begin
            if (valid_out || valid1) early = 1'b1;
            idle(1);
        end
        check({tag, "_no_early_valid"}, 64'(early), 64'd0);
        check({tag, "_valid_t34"}, 64'(valid_out), 64'd1);
        check({tag, "_valid1_t34"}, 64'(valid1), 64'd1);
    endtask

    task automatic check_res(input string tag, input int ex, input int ey, input int exmin,
                             input int eymin, input int exmax, input int eymax, input int ecnt,
                             input logic ef16, input logic ef1);
        check({tag, "_x"}, 64'(x_out), 64'(ex));
        check({tag, "_y"}, 64'(y_out), 64'(ey));
        check({tag, "_xmin"}, 64'(xmin_out), 64'(exmin));
        check({tag, "_ymin"}, 64'(ymin_out), 64'(eymin));
        check({tag, "_xmax"}, 64'(xmax_out), 64'(exmax));
        check({tag, "_ymax"}, 64'(ymax_out), 64'(eymax));
        check({tag, "_count"}, 64'(count_out), 64'(ecnt));
        check({tag, "_found16"}, 64'(found_out), 64'(ef16));
        check({tag, "_found1"}, 64'(found1), 64'(ef1));
        check({tag, "_x1"}, 64'(x1), 64'(ex));
        idle(1);
        check({tag, "_valid_one_cycle"}, 64'(valid_out), 64'd0);
        check({tag, "_x_hold"}, 64'(x_out), 64'(ex));
        check({tag, "_count_hold"}, 64'(count_out), 64'(ecnt));
    endtask

    initial begin
        logic seen;
        rst_in = 1'b1;
        idle(3);
        check("reset_x", 64'(x_out), 64'd0);
        check("reset_xmin", 64'(xmin_out), 64'd0);
        check("reset_count", 64'(count_out), 64'd0);
        check("reset_valid", 64'(valid_out), 64'd0);
        check("reset_dropped", 64'(dropped_out), 64'd0);
        check("reset_found1", 64'(found1), 64'd0);
        rst_in = 1'b0;
        idle(2);

        // Single pixel coincident with frame_end_in
        drive(99, 50, 1'b1, 1'b0, 1'b0);
        drive(5, 5, 1'b0, 1'b1, 1'b0);
        fe_c = cyc;
        drive(100, 50, 1'b1, 1'b1, 1'b1);
        wait_result(fe_c, "single");
        check_res("single", 100, 50, 100, 50, 100, 50, 1, 1'b0, 1'b1);

        // 10x10 block with non-qualified pixels mixed in
        for (int yy = 300; yy <= 309; yy++) begin
            drive(500, yy, 1'b1, 1'b0, 1'b0);
            drive(50, 5, 1'b0, 1'b1, 1'b0);
            for (int xx = 200; xx <= 209; xx++) begin
                drive(xx, yy, 1'b1, 1'b1, 1'((xx == 209) && (yy == 309)));
            end
        end
        fe_c = cyc - 1;
        wait_result(fe_c, "block");
        check_res("block", 204, 304, 200, 300, 209, 309, 100, 1'b1, 1'b1);

        // Empty frame
        drive(10, 10, 1'b1, 1'b0, 1'b0);
        fe_c = cyc;
        drive(11, 10, 1'b1, 1'b0, 1'b1);
        wait_result(fe_c, "empty");
        check_res("empty", 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

        // Three pixels, below the 16-pixel threshold
        drive(10, 10, 1'b1, 1'b1, 1'b0);
        drive(20, 10, 1'b1, 1'b1, 1'b0);
        fe_c = cyc;
        drive(30, 40, 1'b1, 1'b1, 1'b1);
        wait_result(fe_c, "three");
        check_res("three", 20, 20, 10, 10, 30, 40, 3, 1'b0, 1'b1);

        // Second frame_end_in 10 cycles into the divide is dropped
        drive(5, 6, 1'b1, 1'b1, 1'b0);
        fe_c = cyc;
        drive(7, 8, 1'b1, 1'b1, 1'b1);
        while (cyc < fe_c + 10) idle(1);
        drive(999, 999, 1'b1, 1'b1, 1'b1);
        check("drop_pulse", 64'(dropped_out), 64'd1);
        idle(1);
        check("drop_single_pulse", 64'(dropped_out), 64'd0);
        wait_result(fe_c, "inflight");
        check_res("inflight", 6, 7, 5, 6, 7, 8, 2, 1'b0, 1'b1);
        drive(50, 60, 1'b1, 1'b1, 1'b0);
        fe_c = cyc;
        drive(52, 64, 1'b1, 1'b1, 1'b1);
        wait_result(fe_c, "after_drop");
        check_res("after_drop", 51, 62, 50, 60, 52, 64, 2, 1'b0, 1'b1);

        // Coordinate extremes
        drive(0, 0, 1'b1, 1'b1, 1'b0);
        fe_c = cyc;
        drive(2047, 1023, 1'b1, 1'b1, 1'b1);
        wait_result(fe_c, "corners");
        check_res("corners", 1023, 511, 0, 0, 2047, 1023, 2, 1'b0, 1'b1);

        // Reset 15 cycles into the divide aborts the result
        fe_c = cyc;
        drive(300, 400, 1'b1, 1'b1, 1'b1);
        while (cyc < fe_c + 16) idle(1);
        rst_in = 1'b1;
        idle(1);
        rst_in = 1'b0;
        check("rst_mid_x", 64'(x_out), 64'd0);
        check("rst_mid_xmax", 64'(xmax_out), 64'd0);
        check("rst_mid_count", 64'(count_out), 64'd0);
        check("rst_mid_found1", 64'(found1), 64'd0);
        check("rst_mid_valid", 64'(valid_out), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (valid_out || valid1) seen = 1'b1;
            idle(1);
        end
        check("rst_mid_no_valid", 64'(seen), 64'd0);
        fe_c = cyc;
        drive(8, 9, 1'b1, 1'b1, 1'b1);
        wait_result(fe_c, "post_rst");
        check_res("post_rst", 8, 9, 8, 9, 8, 9, 1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
